// File: rtl/main_mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port B arbiter.
package main_mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 14;
  localparam int unsigned DEF_DATA_W    = 18;
  localparam int unsigned BANK_LSB      = 10;
  localparam int unsigned BANK_W        = 4;
  localparam int unsigned DEF_NUM_BANKS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Bank select field of a word address.
  function automatic logic [BANK_W-1:0] bank_idx(input logic [DEF_ADDR_W-1:0] addr);
    return addr[BANK_LSB +: BANK_W];
  endfunction

endpackage

// File: rtl/main_mem_port_arbiter_rr_picker.sv
// Combinational round-robin search: first set request above i_rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_winner_oh_c,
  output logic [IDX_W-1:0]   o_winner_idx_c,
  output logic               o_any_req_c
);

  int unsigned w_idx;

  always_comb begin
    o_winner_oh_c  = '0;
    o_winner_idx_c = '0;
    o_any_req_c    = 1'b0;
    w_idx          = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(i_rr_ptr) + k) % NUM_REQ;
      if (!o_any_req_c && i_req[IDX_W'(w_idx)]) begin
        o_any_req_c                 = 1'b1;
        o_winner_idx_c              = IDX_W'(w_idx);
        o_winner_oh_c[IDX_W'(w_idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/main_mem_port_arbiter.sv
// Round-robin arbiter sharing main-memory port B among NUM_REQ requesters.
// Optional unmapped-bank decode: define MAIN_MEM_ARB_RANGE_CHECK_EN.
module main_mem_port_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                        clka,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_REQ-1:0]          err,
  output logic [ADDR_W-1:0]           mem_addrb,
  output logic                        mem_web,
  output logic [DATA_W-1:0]           mem_dinb,
  input  logic [DATA_W-1:0]           mem_doutb
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_rvalid, w_rvalid_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic                 r_web, w_web_nxt;
  logic [DATA_W-1:0]    r_dinb, w_dinb_nxt;
  logic [IDX_W-1:0]     r_owner, w_owner_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic                 r_is_read, w_is_read_nxt;

  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_any_req;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [DATA_W-1:0]    w_win_wdata;
  logic                 w_win_we;
  logic                 w_unmapped;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req          (req),
    .i_rr_ptr       (r_rr_ptr),
    .o_winner_oh_c  (w_win_oh),
    .o_winner_idx_c (w_win_idx),
    .o_any_req_c    (w_any_req)
  );

  assign w_win_addr  = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
  assign w_win_wdata = req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
  assign w_win_we    = req_we[w_win_idx];

`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
  logic [NUM_REQ-1:0] r_err, w_err_nxt;
  logic               r_unmapped, w_unmapped_nxt;

  assign w_unmapped = 32'(bank_idx(DEF_ADDR_W'(w_win_addr))) >= NUM_BANKS;
  assign err        = r_err;
`else
  assign w_unmapped = 1'b0;
  assign err        = '0;
`endif

  // Next-state and command/return-path decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = '0;
    w_rvalid_nxt  = '0;
    w_rdata_nxt   = r_rdata;
    w_addr_nxt    = r_addr;
    w_web_nxt     = 1'b0;
    w_dinb_nxt    = r_dinb;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_is_read_nxt = r_is_read;
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
    w_err_nxt      = '0;
    w_unmapped_nxt = r_unmapped;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_addr_nxt    = w_win_addr;
          w_dinb_nxt    = w_win_wdata;
          w_web_nxt     = w_win_we && !w_unmapped;
          w_gnt_nxt     = w_win_oh;
          w_owner_nxt   = w_win_idx;
          w_rr_ptr_nxt  = w_win_idx;
          w_is_read_nxt = !w_win_we;
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
          w_err_nxt      = w_unmapped ? w_win_oh : '0;
          w_unmapped_nxt = w_unmapped;
`endif
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: w_state_nxt = r_is_read ? READ : IDLE;
      READ: begin
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
        w_rdata_nxt = r_unmapped ? '0 : mem_doutb;
`else
        w_rdata_nxt = mem_doutb;
`endif
        w_rvalid_nxt[r_owner] = 1'b1;
        w_state_nxt           = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_web     <= 1'b0;
      r_dinb    <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
      r_is_read <= 1'b0;
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
      r_err      <= '0;
      r_unmapped <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_addr    <= w_addr_nxt;
      r_web     <= w_web_nxt;
      r_dinb    <= w_dinb_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_is_read <= w_is_read_nxt;
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
      r_err      <= w_err_nxt;
      r_unmapped <= w_unmapped_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign mem_addrb = r_addr;
  assign mem_web   = r_web;
  assign mem_dinb  = r_dinb;

endmodule

// File: tb/tb_main_mem_port_arbiter.sv
// Self-checking bench for main_mem_port_arbiter with a transaction-level reference model.
module tb_main_mem_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 18;
  localparam int NUM_BANKS = 11;
  localparam int MEM_WORDS = 16384;

  logic                       clka = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ-1:0]         req_we = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata = '0;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         rvalid;
  logic [DATA_W-1:0]          rdata;
  logic [NUM_REQ-1:0]         err;
  logic [ADDR_W-1:0]          mem_addrb;
  logic                       mem_web;
  logic [DATA_W-1:0]          mem_dinb;
  logic [DATA_W-1:0]          mem_doutb = '0;

  int n_checks = 0;
  int n_errors = 0;

  main_mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)
  ) dut (
    .clka(clka), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_addrb(mem_addrb), .mem_web(mem_web), .mem_dinb(mem_dinb), .mem_doutb(mem_doutb)
  );

  always #5 clka = ~clka;

  // Memory environment: 11 populated banks, synchronous read, unmapped reads return 0.
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  logic [DATA_W-1:0] env_mem [MEM_WORDS] = '{default: '0};

  always @(posedge clka) begin
    if (pl_en) env_mem[pl_addr] <= pl_data;
    else if (mem_web && (int'(mem_addrb) / 1024) < NUM_BANKS) env_mem[mem_addrb] <= mem_dinb;
    mem_doutb <= ((int'(mem_addrb) / 1024) < NUM_BANKS) ? env_mem[mem_addrb] : '0;
  end

  // Reference model: arbitration decisions and expected outputs per cycle.
  logic [DATA_W-1:0]  ref_mem [MEM_WORDS] = '{default: '0};
  logic [NUM_REQ-1:0] exp_gnt = '0, exp_rvalid = '0, exp_err = '0;
  logic [DATA_W-1:0]  exp_rdata = '0, exp_dinb = '0, m_rval = '0;
  logic [ADDR_W-1:0]  exp_addr = '0;
  logic               exp_web = 1'b0;
  int                 m_ptr = NUM_REQ - 1, m_owner = 0, m_busy = 0;
  bit                 m_read = 1'b0;

  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      exp_gnt = '0; exp_rvalid = '0; exp_err = '0; exp_rdata = '0;
      exp_dinb = '0; exp_addr = '0; exp_web = 1'b0;
      m_ptr = NUM_REQ - 1; m_owner = 0; m_busy = 0; m_read = 1'b0;
    end else begin
      int  w;
      bit  mapped;
      exp_gnt = '0; exp_rvalid = '0; exp_err = '0; exp_web = 1'b0;
      if (pl_en) ref_mem[pl_addr] = pl_data;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0 && m_read) begin
          exp_rvalid[m_owner] = 1'b1;
          exp_rdata = m_rval;
        end
      end else begin
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
        if (w >= 0) begin
          m_ptr = w; m_owner = w;
          exp_gnt[w] = 1'b1;
          exp_addr = req_addr[w*ADDR_W +: ADDR_W];
          exp_dinb = req_wdata[w*DATA_W +: DATA_W];
          mapped = (int'(exp_addr) / 1024) < NUM_BANKS;
          m_read = !req_we[w];
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
          exp_web = req_we[w] && mapped;
          if (!mapped) exp_err[w] = 1'b1;
`else
          exp_web = req_we[w];
`endif
          if (req_we[w] && mapped) ref_mem[exp_addr] = exp_dinb;
          m_rval = mapped ? ref_mem[exp_addr] : '0;
          m_busy = m_read ? 2 : 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clka) begin
    if (rst_n) begin
      chk("gnt",       32'(gnt),       32'(exp_gnt));
      chk("rvalid",    32'(rvalid),    32'(exp_rvalid));
      chk("err",       32'(err),       32'(exp_err));
      chk("rdata",     32'(rdata),     32'(exp_rdata));
      chk("mem_addrb", 32'(mem_addrb), 32'(exp_addr));
      chk("mem_web",   32'(mem_web),   32'(exp_web));
      chk("mem_dinb",  32'(mem_dinb),  32'(exp_dinb));
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clka); #2;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clka); #2;
    pl_en = 1'b0;
  endtask

  // Single command with observation: cycle numbers relative to the req cycle.
  task automatic do_cmd(input int i, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int gc, output int rc,
                        output logic [DATA_W-1:0] rdv, output int webc, output int errc,
                        output bit held);
    @(posedge clka); #2;
    req[i] = 1'b1; req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a; req_wdata[i*DATA_W +: DATA_W] = d;
    gc = -1; rc = -1; rdv = '0; webc = 0; errc = 0; held = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clka); #2;
      if (gnt[i] && gc < 0) begin gc = c; req[i] = 1'b0; end
      if (mem_web) webc++;
      if (err[i]) errc++;
      if (gc > 0 && rc < 0 && mem_addrb != a) held = 1'b0;
      if (rvalid[i] && rc < 0) begin rc = c; rdv = rdata; end
    end
    req[i] = 1'b0;
  endtask

  task automatic new_cmd(input int i);
    req[i] = 1'b1;
    req_we[i] = ($urandom_range(0, 2) == 0);
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(($urandom_range(0, 15) << 10) | $urandom_range(0, 15));
    req_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  initial begin
    int gc, rc, webc, errc, ng;
    int order [12];
    bit held;
    logic [DATA_W-1:0] rdv, rdv2;

    repeat (3) @(posedge clka);
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_web", 32'(mem_web), 32'd0);
    chk("rst_addr", 32'(mem_addrb), 32'd0);
    rst_n = 1'b1;

    preload(14'h0405, 18'h2ABCD);
    preload(14'h03FF, 18'h11111);
    preload(14'h0400, 18'h22222);

    // Single read by requester 2.
    do_cmd(2, 1'b0, 14'h0405, '0, gc, rc, rdv, webc, errc, held);
    chk("rd_gnt_cycle", 32'(gc), 32'd1);
    chk("rd_rvalid_cycle", 32'(rc), 32'd3);
    chk("rd_rdata", 32'(rdv), 32'h2ABCD);
    chk("rd_addr_held", 32'(held), 32'd1);

    // Write then read back by requester 0.
    do_cmd(0, 1'b1, 14'h27FF, 18'h3FFFF, gc, rc, rdv, webc, errc, held);
    chk("wr_gnt_cycle", 32'(gc), 32'd1);
    chk("wr_web_cycles", 32'(webc), 32'd1);
    chk("wr_no_rvalid", 32'(rc), 32'hFFFF_FFFF);
    do_cmd(0, 1'b0, 14'h27FF, '0, gc, rc, rdv, webc, errc, held);
    chk("wr_rb_rvalid_cycle", 32'(rc), 32'd3);
    chk("wr_rb_rdata", 32'(rdv), 32'h3FFFF);

    // Bank boundary reads.
    do_cmd(1, 1'b0, 14'h03FF, '0, gc, rc, rdv, webc, errc, held);
    do_cmd(1, 1'b0, 14'h0400, '0, gc, rc, rdv2, webc, errc, held);
    chk("bnd_rdata_lo", 32'(rdv), 32'h11111);
    chk("bnd_rdata_hi", 32'(rdv2), 32'h22222);

    // Unmapped bank accesses.
    do_cmd(3, 1'b1, 14'h2C00, 18'h155AA, gc, rc, rdv, webc, errc, held);
    chk("rng_wr_gnt_cycle", 32'(gc), 32'd1);
`ifdef MAIN_MEM_ARB_RANGE_CHECK_EN
    chk("rng_wr_err", 32'(errc), 32'd1);
    chk("rng_wr_web", 32'(webc), 32'd0);
`else
    chk("rng_wr_err", 32'(errc), 32'd0);
    chk("rng_wr_web", 32'(webc), 32'd1);
`endif
    do_cmd(3, 1'b0, 14'h3000, '0, gc, rc, rdv, webc, errc, held);
    chk("rng_rd_rvalid_cycle", 32'(rc), 32'd3);
    chk("rng_rd_rdata", 32'(rdv), 32'd0);

    // Reset during READ aborts the read.
    @(posedge clka); #2;
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: ADDR_W] = 14'h0405;
    @(posedge clka); #2;
    req[0] = 1'b0;
    @(posedge clka); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_addr", 32'(mem_addrb), 32'd0);
    chk("mid_rst_web", 32'(mem_web), 32'd0);
    repeat (2) @(posedge clka);
    #2;
    chk("mid_rst_rvalid_hold", 32'(rvalid), 32'd0);
    rst_n = 1'b1;

    // Fairness: all requesters hold reads continuously.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_we[i] = 1'b0;
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(16 * i);
    end
    req = '1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 12; c++) begin
      @(posedge clka); #2;
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && ng < 12) begin order[ng] = i; ng++; end
    end
    req = '0;
    chk("fair_grant_count", 32'(ng), 32'd12);
    for (int k = 0; k < 12; k++) chk("fair_order", 32'(order[k]), 32'(k % NUM_REQ));

    // Randomized traffic with hold/withdraw/re-request behaviour.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clka); #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 1) new_cmd(i);
          else req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          new_cmd(i);
        end
      end
    end
    req = '0;
    repeat (6) @(posedge clka);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main_mem_port_arbiter.md
Name: main_mem_port_arbiter

Overview:
- Shares port B of the 11-bank main memory (18-bit data, 14-bit word address) among NUM_REQ requesters, e.g. VGA fetch, I/O DMA and debug loader.
- Round-robin arbitration with a req/gnt handshake.
- Keeps the memory address stable until read data has been captured, because the memory's bank output mux follows the live address.
- Returns read data to the winning requester with a one-cycle rvalid pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 14, word address width; bits [13:10] select the bank.
- DATA_W, 18, data word width.
- NUM_BANKS, 11, number of populated 1024-word banks; bank indices NUM_BANKS..15 are unmapped.

Ports:
- clka  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held with its command until gnt.
- req_we  in  NUM_REQ  per-requester write flag (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: command accepted.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata belongs to that requester.
- rdata  out  DATA_W  shared read-data register.
- err  out  NUM_REQ  one-cycle pulse marking an unmapped access (optional feature).
- mem_addrb  out  ADDR_W  to memory port B address.
- mem_web  out  1  to memory port B write enable.
- mem_dinb  out  DATA_W  to memory port B write data.
- mem_doutb  in  DATA_W  from memory port B read data.

Behaviour:
- Reset: all outputs are 0 asynchronously, including mem_web and mem_addrb. FSM goes to IDLE. rr_ptr = NUM_REQ-1, so requester 0 wins first. Reset mid-transaction aborts it: no gnt, no rvalid, no write.
- FSM states: IDLE, ISSUE, READ.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from rr_ptr+1, with wrap-around.
  - At the clock edge: mem_addrb, mem_dinb and mem_web (= req_we of the winner) are registered. gnt[winner] = 1, owner = winner, rr_ptr = winner. Go to ISSUE.
  - With no requests the FSM stays in IDLE and mem_web = 0.
- ISSUE: gnt pulse is visible; memory samples the command at the end of this cycle. At the edge, mem_web returns to 0 and gnt clears.
  - Write: go to IDLE.
  - Read: go to READ, holding mem_addrb.
- READ: mem_doutb is valid. At the edge, rdata takes mem_doutb, rvalid[owner] = 1 for one cycle, and the FSM goes to IDLE. rdata holds its value until the next read capture.
- Timing: write occupies 2 cycles, gnt in cycle 1 after the req cycle. Read occupies 3 cycles; rvalid is asserted in cycle 3 if req was first seen in cycle 0.
- mem_addrb changes only on the IDLE to ISSUE edge, never while a read is pending.
- Requests raised during ISSUE or READ wait; they are evaluated in the next IDLE cycle.
- A requester may drop req before gnt; the request is withdrawn and nothing is issued for it.
- A requester may re-request in the cycle gnt is visible; that counts as a new request.
- Simultaneous requests are granted in round-robin order. A requester that holds req continuously waits at most NUM_REQ-1 grants.
- req_we is ignored for rvalid purposes: writes never produce rvalid.

Optional Feature:
- Macro: MAIN_MEM_ARB_RANGE_CHECK_EN.
- Enabled: a winner whose addr[13:10] >= NUM_BANKS is still granted. mem_web is forced to 0 for it, err[owner] pulses together with gnt, and a read goes to READ with rdata = 0 and rvalid pulsed as normal.
- Disabled: no range decode is present, err is tied to 0, and the access is passed to the memory unchanged (the memory ignores the write and returns 0 on reads).

Decomposition:
- Shared package main_mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, READ);
  - the default constants ADDR_W = 14, DATA_W = 18, BANK_LSB = 10, NUM_BANKS = 11;
  - a bank-index function.
- One sub-module, rr_picker: combinational round-robin search.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner, winner index, any-request flag.
- FSM, command registers and return path stay in the top module.

Test Plan:
- Single read: requester 2 reads 0x0405, which was preloaded with 0x2ABCD. Expect gnt[2] in cycle 1, mem_addrb = 0x0405 held through READ, rvalid[2] and rdata = 0x2ABCD in cycle 3.
- Write then read: requester 0 writes 0x3FFFF to 0x27FF (bank 9, last word), then reads it back. Expect mem_web high for exactly one cycle, followed by rvalid[0] with rdata = 0x3FFFF.
- Fairness: all 4 requesters hold read requests continuously for 12 grants. Expect grant order 0,1,2,3,0,1,... with no requester waiting longer than 3 grants.
- Bank boundary: requester 1 reads 0x03FF then 0x0400 with distinct preloaded data. Expect each rdata to match its own bank, proving the address is held through READ.
- Reset mid-read: assert rst_n = 0 during READ. Expect all outputs 0 immediately, no rvalid, and after release requester 0 wins first.
- Range check (macro on): requester 3 writes 0x2C00 (bank 11). Expect gnt[3] and err[3] pulses, mem_web stays 0. A read of 0x3000 gives rvalid[3] with rdata = 0. With the macro off, err stays 0.
